// File: rtl/bus_pkg.sv
// Shared constants and state encoding for the bus cycle sequencer.
// Holds the T-state markers, direction codes and the default parameter values.
package bus_pkg;

    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 16;

    localparam logic [2:0] T_FIRST       = 3'd0;
    localparam logic [2:0] T_LAST        = 3'd7;
    localparam logic [2:0] WAIT_T_DEF    = 3'd4;
    localparam logic [2:0] CAPTURE_T_DEF = 3'd6;

    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LAST   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/bus_cycle_sequencer_if.sv
// Core-request and bus-side signal bundle for the bus cycle sequencer.
// master is the sequencer's view; slave is the core/bus environment's view.
interface bus_cycle_sequencer_if
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             ack;
    logic             err;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] ADDR;
    logic [WIDTH-1:0] DOUT;
    logic [WIDTH-1:0] DIN;
    logic             mem_rdy;
    logic             bus_hold;
    logic             busint;
    logic             dtr_;
    logic             stall_;
    logic [2:0]       t_state;

    modport master (
        input  req, we, addr, wdata, DIN, mem_rdy, bus_hold,
        output busy, ack, err, rdata, ADDR, DOUT, busint, dtr_, stall_, t_state
    );

    modport slave (
        output req, we, addr, wdata, DIN, mem_rdy, bus_hold,
        input  busy, ack, err, rdata, ADDR, DOUT, busint, dtr_, stall_, t_state
    );

endinterface

// File: rtl/bus_wait_timer.sv
// Wait-state counter: counts enabled cycles since the last clear and flags
// the last permitted wait cycle before a timeout abort.
module bus_wait_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign tc_c = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Bus cycle sequencer: turns single-beat core load/store requests into a
// T0..T7 bus cycle with wait-state insertion, hold freeze and timeout abort.
module bus_cycle_sequencer
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter logic [2:0]  WAIT_T    = WAIT_T_DEF,
    parameter logic [2:0]  CAPTURE_T = CAPTURE_T_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input logic                   clk,
    input logic                   rst_,
    bus_cycle_sequencer_if.master bus
);

    seq_state_e       state_q, state_d;
    logic [2:0]       t_q, t_d;
    logic             busint_q, busint_d;
    logic             busy_q, busy_d;
    logic             dtr_q, dtr_d;
    logic             stall_q, stall_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             tmr_clr_c, tmr_en_c, tmr_tc_c;

    bus_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk  (clk),
        .rst_ (rst_),
        .clr  (tmr_clr_c),
        .en   (tmr_en_c),
        .tc_c (tmr_tc_c)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ST_IDLE;
            t_q      <= T_FIRST;
            busint_q <= 1'b0;
            busy_q   <= 1'b0;
            dtr_q    <= DIR_READ;
            stall_q  <= 1'b1;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            dout_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            busint_q <= busint_d;
            busy_q   <= busy_d;
            dtr_q    <= dtr_d;
            stall_q  <= stall_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state and next-output values; priority in ACTIVE is hold, then wait, then advance.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        busint_d  = busint_q;
        busy_d    = busy_q;
        dtr_d     = dtr_q;
        stall_d   = 1'b1;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rdata_d   = rdata_q;
        tmr_clr_c = 1'b0;
        tmr_en_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req && !bus.bus_hold) begin
                    state_d   = ST_ACTIVE;
                    t_d       = T_FIRST;
                    addr_d    = bus.addr;
                    dout_d    = bus.wdata;
                    dtr_d     = bus.we ? DIR_WRITE : DIR_READ;
                    busint_d  = 1'b1;
                    busy_d    = 1'b1;
                    tmr_clr_c = 1'b1;
                end
            end

            ST_ACTIVE: begin
                if (bus.bus_hold) begin
                    stall_d = 1'b0;
                end else if ((t_q == WAIT_T) && !bus.mem_rdy) begin
                    if (tmr_tc_c) begin
                        // Timeout skips the capture T-state, so rdata is left untouched.
                        state_d = ST_LAST;
                        t_d     = T_LAST;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        tmr_en_c = 1'b1;
                    end
                end else begin
                    if ((t_q == CAPTURE_T) && (dtr_q == DIR_READ)) begin
                        rdata_d = bus.DIN;
                    end
                    if (t_q == (T_LAST - 3'd1)) begin
                        state_d = ST_LAST;
                        ack_d   = 1'b1;
                    end
                    t_d = 3'(t_q + 3'd1);
                end
            end

            ST_LAST: begin
                state_d  = ST_IDLE;
                t_d      = T_FIRST;
                busint_d = 1'b0;
                busy_d   = 1'b0;
                dtr_d    = DIR_READ;
            end

            default: begin
                state_d = ST_IDLE;
                t_d     = T_FIRST;
            end
        endcase
    end

    assign bus.t_state = t_q;
    assign bus.busint  = busint_q;
    assign bus.busy    = busy_q;
    assign bus.dtr_    = dtr_q;
    assign bus.stall_  = stall_q;
    assign bus.ack     = ack_q;
    assign bus.err     = err_q;
    assign bus.ADDR    = addr_q;
    assign bus.DOUT    = dout_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: doc/bus_cycle_sequencer.md
Name: bus_cycle_sequencer

Overview:
- Upstream driver for the non-multiplexed bus interface handshake block.
- Accepts single-beat load/store requests from the core's memory stage.
- Generates the 3-bit T-state sequence plus busint, dtr_, stall_, ADDR and DOUT for each bus cycle.
- Inserts wait states from mem_rdy, captures read data, and returns ack/err/rdata to the core.

Parameters:
WIDTH, 32, address and data width
WAIT_T, 3'd4, T-state at which mem_rdy is sampled and the sequence may freeze
CAPTURE_T, 3'd6, T-state whose clock edge captures DIN into rdata on reads
TIMEOUT, 16, maximum wait cycles at WAIT_T before the cycle is aborted with err

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_  in  1  asynchronous active-low reset
req  in  1  core request; held with addr/we/wdata stable until ack
we  in  1  1 = write, 0 = read
addr  in  WIDTH  byte address
wdata  in  WIDTH  store data
busy  out  1  high from accept through the T7 cycle
ack  out  1  one-cycle completion pulse
err  out  1  qualifies ack: the cycle timed out
rdata  out  WIDTH  captured load data, valid with ack when we=0 and err=0
ADDR  out  WIDTH  latched bus address
DOUT  out  WIDTH  latched bus write data
DIN  in  WIDTH  bus read data
mem_rdy  in  1  memory ready; low at WAIT_T inserts wait states
bus_hold  in  1  external hold request; freezes the sequence
busint  out  1  bus cycle in progress
dtr_  out  1  direction: 1 = read, 0 = write
stall_  out  1  low while bus_hold freezes an active cycle (suppresses strobes downstream)
t_state  out  3  current T-state, 0..7

Behaviour:
- Reset (async, rst_=0) values:
  - t_state=0, busint=0, dtr_=1, stall_=1.
  - ADDR=0, DOUT=0, rdata=0.
  - ack=0, err=0, busy=0, wait counter=0.
  - Reset mid-cycle aborts the cycle immediately: no ack is issued, and strobes go inactive because busint=0.
- State IDLE (busint=0, t_state=0):
  - On an edge with req=1 and bus_hold=0, latch addr→ADDR and wdata→DOUT.
  - Set dtr_=~we, busint=1, busy=1, clear the wait counter, and enter ACTIVE at t_state=0.
  - bus_hold=1 blocks acceptance.
- State ACTIVE (t_state 0..6): t_state increments by 1 per clock except in these cases, listed in priority order:
  - bus_hold=1: freeze t_state and drive stall_=0. The wait counter does not count. stall_ returns to 1 on the edge after bus_hold drops.
  - t_state==WAIT_T and mem_rdy=0: freeze and increment the wait counter.
    - When the counter reaches TIMEOUT-1 and mem_rdy is still 0, the next edge forces t_state=7 and sets err=1.
    - Read data is not captured in that case.
  - mem_rdy is sampled only at WAIT_T. Pulses at other T-states are ignored and not latched.
- Read capture:
  - On the edge leaving t_state==CAPTURE_T with dtr_=1, rdata<=DIN.
  - rdata holds until the next captured read.
- State T7 (t_state=7):
  - ack=1 for exactly this cycle. err is valid in the same cycle and clears with ack.
  - bus_hold is ignored in T7.
  - The next edge returns to IDLE: busint=0, t_state=0, busy=0, dtr_=1.
  - T7 never chains directly into a new cycle; a minimum of one IDLE cycle follows every bus cycle.
- Timing:
  - Zero-wait latency from the accept edge to ack is 8 cycles.
  - Back-to-back throughput is 9 cycles per transfer.
  - Each wait state or hold cycle adds 1.
- Ignored inputs: changes to req/addr/we/wdata while busy=1 are ignored.
- Wrap-around: t_state never wraps 7→0 inside ACTIVE; the only 7→0 path is through IDLE.

Decomposition:
- Shared package (bus_pkg): T_FIRST=3'd0, T_LAST=3'd7, DIR_READ=1'b1, DIR_WRITE=1'b0, and a 2-bit state encoding IDLE/ACTIVE/LAST.
- The WAIT_T and CAPTURE_T defaults also live in the package.
- Sub-module bus_wait_timer: clear/enable inputs and a terminal-count output for TIMEOUT, with a clog2-sized counter.

Test Plan:
- Read, zero waits: addr=0x100, DIN=0xDEADBEEF, mem_rdy=1 → busint high for 8 cycles, dtr_=1, t_state 0..7, ack 8 cycles after accept, rdata=0xDEADBEEF, err=0.
- Write: addr=0x200, wdata=0x12345678 → ADDR=0x200, DOUT=0x12345678 and dtr_=0 for the whole cycle, ack at 8 cycles, rdata unchanged.
- Three wait states: mem_rdy low for 3 cycles at t_state=4 → t_state holds at 4 for 4 cycles total, ack at 11 cycles, correct rdata.
- Timeout: mem_rdy held 0 → t_state=7 after 16 cycles at 4, ack=1 with err=1, rdata not updated; the next request completes normally with err=0.
- Hold: bus_hold=1 for 2 cycles at t_state=2 → stall_=0 and t_state=2 for those cycles, wait counter unchanged, ack at 10 cycles; bus_hold=1 in IDLE delays acceptance.
- Reset mid-cycle: rst_ low at t_state=5 → busint=0, t_state=0, dtr_=1, no ack; after release, a new read completes in 8 cycles.
